// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes, FSM states and
// shift-kind decoding, also imported by the ALU decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_EQ     = 4'b1000;
    localparam logic [3:0] ALU_NE     = 4'b1001;
    localparam logic [3:0] ALU_SUB    = 4'b1010;
    localparam logic [3:0] ALU_RSVD   = 4'b1011;
    localparam logic [3:0] ALU_LT     = 4'b1100;
    localparam logic [3:0] ALU_GE     = 4'b1101;
    localparam logic [3:0] ALU_LTU    = 4'b1110;
    localparam logic [3:0] ALU_GEU    = 4'b1111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'b00,
        SH_RL = 2'b01,
        SH_RA = 2'b10
    } shift_kind_t;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

    function automatic shift_kind_t shift_kind(input logic [3:0] ctrl);
        shift_kind_t kind;
        kind = SH_LL;
        if (ctrl == ALU_SRL) kind = SH_RL;
        if (ctrl == ALU_SRA) kind = SH_RA;
        return kind;
    endfunction

endpackage

// File: rtl/alu_compare.sv
// Combinational comparator: computes eq / signed-lt / unsigned-lt and selects
// the branch flag for the compare control codes (0 for everything else).
module alu_compare
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             flag
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    // NOTE: every output of an always_comb block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        flag = 1'b0;
        case (ctrl)
            ALU_EQ:  flag = eq;
            ALU_NE:  flag = !eq;
            ALU_LT:  flag = lt_s;
            ALU_GE:  flag = !lt_s;
            ALU_LTU: flag = lt_u;
            ALU_GEU: flag = !lt_u;
            default: flag = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes on both sides; single-cycle
// logic/arith/compare ops and an iterative 1-bit-per-cycle shifter.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    shift_kind_t      sh_kind;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_next;
    logic [SHW-1:0]   sh_cnt;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] op_result;
    logic             op_flag;
    logic             cmp_flag;
    logic             accept;

    assign sh_amt   = src_b[SHW-1:0];
    // out_ready -> in_ready is deliberately the one combinational path, so a
    // drained result frees the slot for a new op in the same cycle.
    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_SHIFT);

    alu_compare #(.WIDTH(WIDTH)) u_compare (
        .ctrl (alu_ctrl),
        .a    (src_a),
        .b    (src_b),
        .flag (cmp_flag)
    );

    always_comb begin
        op_result = '0;
        op_flag   = 1'b0;
        case (alu_ctrl)
            ALU_ADD:    op_result = src_a + src_b;
            ALU_SUB:    op_result = src_a - src_b;
            ALU_PASS_B: op_result = src_b;
            ALU_AND:    op_result = src_a & src_b;
            ALU_OR:     op_result = src_a | src_b;
            ALU_XOR:    op_result = src_a ^ src_b;
            // Only reached for a zero shift amount; non-zero goes through SHIFT.
            ALU_SLL, ALU_SRL, ALU_SRA: op_result = src_a;
            ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU: begin
                op_flag   = cmp_flag;
                op_result = {{(WIDTH-1){1'b0}}, cmp_flag};
            end
            default: begin
                op_result = '0;
                op_flag   = 1'b0;
            end
        endcase
    end

    always_comb begin
        sh_next = sh_reg;
        case (sh_kind)
            SH_LL:   sh_next = {sh_reg[WIDTH-2:0], 1'b0};
            SH_RL:   sh_next = {1'b0, sh_reg[WIDTH-1:1]};
            SH_RA:   sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
            default: sh_next = sh_reg;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the later
    // out_valid assignment on accept overrides the earlier clear on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flag      <= 1'b0;
            sh_reg    <= '0;
            sh_cnt    <= '0;
            sh_kind   <= SH_LL;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_shift(alu_ctrl) && (sh_amt != '0)) begin
                            sh_reg  <= src_a;
                            sh_cnt  <= sh_amt;
                            sh_kind <= shift_kind(alu_ctrl);
                            state   <= ST_SHIFT;
                        end else begin
                            result    <= op_result;
                            flag      <= op_flag;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    sh_reg <= sh_next;
                    sh_cnt <= sh_cnt - 1'b1;
                    if (sh_cnt == SHW'(1)) begin
                        result    <= sh_next;
                        flag      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
